downsamp_ctrl: RTL
==================

// Module: downsamp_ctrl
// PURPOSE
//  Phase scheduler for the downsampler in the RX chain. Counts valid oversampled
//  input samples modulo the oversampling factor and emits one enable strobe per
//  symbol at a programmable sampling phase.
//  Phase updates (from the phase-search / eye-opening logic) are deferred to a
//  symbol boundary, so each symbol window gets exactly one strobe.
// PARAMETERS
//  NB_OS      3   width of os factor, phase and counter; os range 1..2^NB_OS-1
//  NB_SYMCNT  16  width of symbol counter (DOWNSAMP_CTRL_STAT_EN only)
// PORTS
//  clk           in   1          system clock, rising edge
//  i_reset_n     in   1          asynchronous reset, active low
//  i_start       in   1          pulse: IDLE -> ARM
//  i_stop        in   1          pulse: any state -> IDLE
//  i_os_fact     in   NB_OS      oversampling factor N; sampled only in ARM
//  i_phase       in   NB_OS      requested sampling phase 0..N-1
//  i_phase_ld    in   1          pulse: load i_phase into pending register
//  i_is_valid    in   1          upstream oversampled sample valid this cycle
//  o_dwsamp_en   out  1          enable to downsampler, aligned with i_is_valid
//  o_ld_ack      out  1          1-cycle pulse: pending phase applied
//  o_busy        out  1          1 when state != IDLE
//  o_phase_cur   out  NB_OS      phase currently in use
//  o_sym_cnt     out  NB_SYMCNT  strobes issued since ARM (macro only)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, counter=0, os_act=1,
//    phase_act=0, pending clear; o_dwsamp_en, o_ld_ack, o_busy = 0;
//    o_phase_cur=0; o_sym_cnt=0.
//  - FSM IDLE/ARM/RUN, state register only:
//    IDLE --i_start--> ARM; ARM --(1 cycle)--> RUN; RUN --i_stop--> IDLE.
//    i_stop in ARM -> IDLE. i_stop and i_start in the same cycle: stop wins.
//    i_start outside IDLE is ignored.
//  - ARM:
//    os_act = i_os_fact, with 0 forced to 1.
//    phase_act = i_phase, saturated to os_act-1.
//    counter=0; pending clear; o_sym_cnt=0.
//  - RUN: on each cycle with i_is_valid=1, counter = (counter==os_act-1) ? 0 : counter+1.
//    Counter holds when i_is_valid=0.
//  - o_dwsamp_en = (state==RUN) & i_is_valid & (counter==phase_act). Combinational
//    from registers and i_is_valid, so zero latency: the strobe qualifies the
//    same-cycle sample. Low in IDLE/ARM and from the cycle after i_stop.
//  - os_act=1: every valid sample is strobed.
//  - i_phase_ld: i_phase, saturated to os_act-1, goes into the pending register.
//    A later ld before the apply overwrites pending (last one wins).
//  - Apply point: a RUN cycle with i_is_valid=1 and counter==os_act-1 (wrap).
//    phase_act <= pending, pending clears, o_ld_ack=1 for the next cycle.
//  - i_phase_ld in the wrap cycle itself bypasses pending and is applied at
//    that wrap.
//  - i_phase_ld in IDLE/ARM writes phase_act directly, with o_ld_ack next cycle.
//    ARM still re-samples i_phase.
//  - i_os_fact changes during RUN are ignored until the next ARM.
//  - o_phase_cur = phase_act.
// CONFIGURATION
//  DOWNSAMP_CTRL_STAT_EN defined:
//    o_sym_cnt increments on each o_dwsamp_en and wraps at 2^NB_SYMCNT-1 -> 0.
//  Not defined:
//    o_sym_cnt is tied to 0 and the counter register is not built. Port list
//    is unchanged.
// TESTING
//  1 Reset mid-RUN (i_reset_n low, async) -> o_dwsamp_en=0, o_busy=0 at once;
//    state IDLE after release.
//  2 N=4, phase=2, i_is_valid const 1, start -> en high at valid samples
//    2,6,10,... (count from first RUN cycle); o_sym_cnt=3 after 12 samples.
//  3 N=4, phase=1, i_is_valid toggling 1/0 -> en only on valid cycles; one strobe
//    per 4 valid samples; counter holds while invalid.
//  4 N=4, phase 3 -> ld phase 0 mid-symbol -> old strobe still at phase 3;
//    o_ld_ack after wrap; next strobe on next valid sample; no symbol gets 0 or 2 strobes.
//  5 ld in wrap cycle, ld twice before wrap (1 then 2), ld phase=7 with N=4
//    -> bypass applied; phase 2 wins; saturated to 3.
//  6 i_start and i_stop same cycle -> stays IDLE.
//    i_os_fact=0 -> every valid sample strobed.
//    i_os_fact changed 4->5 in RUN -> period stays 4.

Source files
------------

// File: rtl/downsamp_ctrl.sv
// Downsampler phase scheduler: counts valid oversampled samples modulo os factor and strobes one sample per symbol.
// Optional symbol-strobe counter enabled by defining DOWNSAMP_CTRL_STAT_EN.
module downsamp_ctrl #(
   parameter int NB_OS     = 3,
   parameter int NB_SYMCNT = 16
) (
   input  logic                 clk,
   input  logic                 i_reset_n,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic [NB_OS-1:0]     i_os_fact,
   input  logic [NB_OS-1:0]     i_phase,
   input  logic                 i_phase_ld,
   input  logic                 i_is_valid,
   output logic                 o_dwsamp_en,
   output logic                 o_ld_ack,
   output logic                 o_busy,
   output logic [NB_OS-1:0]     o_phase_cur,
   output logic [NB_SYMCNT-1:0] o_sym_cnt
);

   localparam logic [NB_OS-1:0] OS_ONE = NB_OS'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

   state_t           state_q, state_d;
   logic [NB_OS-1:0] cnt_q;
   logic [NB_OS-1:0] os_act_q;
   logic [NB_OS-1:0] phase_act_q;
   logic [NB_OS-1:0] pend_q;
   logic             pend_vld_q;
   logic             ack_q;

   logic [NB_OS-1:0] os_arm;
   logic [NB_OS-1:0] os_max;
   logic [NB_OS-1:0] ld_sat;
   logic             wrap;

   function automatic logic [NB_OS-1:0] sat_phase(input logic [NB_OS-1:0] ph,
                                                  input logic [NB_OS-1:0] os);
      logic [NB_OS-1:0] top;
      top = os - OS_ONE;
      return (ph > top) ? top : ph;
   endfunction

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= ST_IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (i_stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (i_start) state_d = ST_ARM;
            ST_ARM:  state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign os_arm = (i_os_fact == '0) ? OS_ONE : i_os_fact;
   assign os_max = os_act_q - OS_ONE;
   assign ld_sat = sat_phase(i_phase, os_act_q);
   assign wrap   = (state_q == ST_RUN) && i_is_valid && (cnt_q == os_max);

   // A load landing exactly on the wrap skips the pending slot so that symbol boundary still takes it.
   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt_q       <= '0;
         os_act_q    <= OS_ONE;
         phase_act_q <= '0;
         pend_q      <= '0;
         pend_vld_q  <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_phase_ld) begin
                  phase_act_q <= ld_sat;
                  ack_q       <= 1'b1;
               end
            end
            ST_ARM: begin
               os_act_q    <= os_arm;
               phase_act_q <= sat_phase(i_phase, os_arm);
               cnt_q       <= '0;
               pend_vld_q  <= 1'b0;
               ack_q       <= i_phase_ld;
            end
            ST_RUN: begin
               if (i_is_valid) cnt_q <= wrap ? '0 : cnt_q + OS_ONE;
               if (wrap) begin
                  if (i_phase_ld)      phase_act_q <= ld_sat;
                  else if (pend_vld_q) phase_act_q <= pend_q;
                  ack_q      <= i_phase_ld | pend_vld_q;
                  pend_vld_q <= 1'b0;
               end else if (i_phase_ld) begin
                  pend_q     <= ld_sat;
                  pend_vld_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dwsamp_en = (state_q == ST_RUN) && i_is_valid && (cnt_q == phase_act_q);
   assign o_ld_ack    = ack_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_phase_cur = phase_act_q;

`ifdef DOWNSAMP_CTRL_STAT_EN
   logic [NB_SYMCNT-1:0] sym_cnt_q;

   always_ff @(posedge clk or negedge i_reset_n) begin
      if (!i_reset_n)              sym_cnt_q <= '0;
      else if (state_q == ST_ARM)  sym_cnt_q <= '0;
      else if (o_dwsamp_en)        sym_cnt_q <= sym_cnt_q + NB_SYMCNT'(1);
   end

   assign o_sym_cnt = sym_cnt_q;
`else
   assign o_sym_cnt = '0;
`endif

endmodule
